// File: rtl/mem_burst_pkg.sv
// Shared types for the memory burst engine: FSM state encoding, grant direction
// constants and the command sizing helper.
package mem_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_t;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  function automatic int unsigned min_size(input int unsigned remain,
                                           input int unsigned max_size);
    return (remain < max_size) ? remain : max_size;
  endfunction

endpackage

// File: rtl/mem_burst_cmd_gen.sv
// Local command generator: walks the burst address in MAX_SIZE steps and sizes
// each command, with the tail command trimmed to the beats still outstanding.
module mem_burst_cmd_gen #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned LEN_W    = 10,
  parameter int unsigned SIZE_W   = 2,
  parameter int unsigned MAX_SIZE = 2
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_accept,
  output logic [ADDR_W-1:0] o_address,
  output logic [SIZE_W-1:0] o_size,
  output logic              o_last
);
  import mem_burst_pkg::*;

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(MAX_SIZE);
  localparam logic [LEN_W:0]    STEP_L = (LEN_W+1)'(MAX_SIZE);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W:0]    r_cmd_cnt;
  logic [LEN_W:0]    w_remain;

  // One spare bit so the count can step past a length that is not a multiple of MAX_SIZE.
  assign w_remain  = {1'b0, i_len} - r_cmd_cnt;
  assign o_size    = SIZE_W'(min_size(32'(w_remain), MAX_SIZE));
  assign o_last    = (w_remain <= STEP_L);
  assign o_address = r_addr;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_addr    <= '0;
      r_cmd_cnt <= '0;
    end else if (i_load) begin
      r_addr    <= i_load_addr;
      r_cmd_cnt <= '0;
    end else if (i_accept) begin
      r_addr    <= r_addr + STEP_A;
      r_cmd_cnt <= r_cmd_cnt + STEP_L;
    end
  end

endmodule

// File: rtl/mem_burst_arb.sv
// Round-robin read/write burst engine in front of a DDR2 local interface.
// Optional stall watchdog enabled by defining MEM_BURST_TIMEOUT_EN.
module mem_burst_arb #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned SIZE_W      = 2,
  parameter int unsigned MAX_SIZE    = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                i_mem_clk,
  input  logic                i_rst,
  input  logic                i_rd_burst_req,
  input  logic [LEN_W-1:0]    i_rd_burst_len,
  input  logic [ADDR_W-1:0]   i_rd_burst_addr,
  output logic                o_rd_burst_ack,
  output logic                o_rd_burst_data_valid,
  output logic [DATA_W-1:0]   o_rd_burst_data,
  input  logic                i_wr_burst_req,
  input  logic [LEN_W-1:0]    i_wr_burst_len,
  input  logic [ADDR_W-1:0]   i_wr_burst_addr,
  output logic                o_wr_burst_ack,
  output logic                o_wr_burst_data_req,
  input  logic [DATA_W-1:0]   i_wr_burst_data,
  output logic                o_burst_finish,
  output logic                o_burst_busy,
  output logic                o_burst_error,
  input  logic                i_local_initial_done,
  input  logic                i_local_ready,
  output logic                o_local_read_req,
  output logic                o_local_write_req,
  output logic [ADDR_W-1:0]   o_local_address,
  output logic [SIZE_W-1:0]   o_local_size,
  output logic [DATA_W/8-1:0] o_local_be,
  input  logic                i_local_wdata_req,
  output logic [DATA_W-1:0]   o_local_wdata,
  input  logic                i_local_rdata_valid,
  input  logic [DATA_W-1:0]   i_local_rdata
);
  import mem_burst_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_zero_fin;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat_cnt;

  logic              w_clr;
  logic              w_idle;
  logic              w_rd_grant;
  logic              w_wr_grant;
  logic              w_grant;
  logic [LEN_W-1:0]  w_grant_len;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_rd_act;
  logic              w_wr_act;
  logic              w_in_cmd;
  logic              w_strobe;
  logic              w_accept;
  logic              w_final;
  logic              w_cmd_last;
  logic              w_timeout;

  // An uncalibrated controller is treated exactly like reset.
  assign w_clr  = i_rst | ~i_local_initial_done;
  assign w_idle = (r_state == ST_IDLE);

  assign w_rd_grant = w_idle & ~w_clr & i_rd_burst_req &
                      (~i_wr_burst_req | (r_last_grant == GRANT_WR));
  assign w_wr_grant = w_idle & ~w_clr & i_wr_burst_req &
                      (~i_rd_burst_req | (r_last_grant == GRANT_RD));
  assign w_grant      = w_rd_grant | w_wr_grant;
  assign w_grant_len  = w_rd_grant ? i_rd_burst_len  : i_wr_burst_len;
  assign w_grant_addr = w_rd_grant ? i_rd_burst_addr : i_wr_burst_addr;

  assign w_rd_act = (r_state == ST_RD_CMD) | (r_state == ST_RD_WAIT);
  assign w_wr_act = (r_state == ST_WR_CMD) | (r_state == ST_WR_WAIT);
  assign w_in_cmd = (r_state == ST_RD_CMD) | (r_state == ST_WR_CMD);

  assign w_strobe = (w_rd_act & i_local_rdata_valid) | (w_wr_act & i_local_wdata_req);
  assign w_accept = w_in_cmd & i_local_ready;
  assign w_final  = w_strobe & (r_beat_cnt == (r_len - LEN_W'(1)));

  mem_burst_cmd_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .SIZE_W   (SIZE_W),
    .MAX_SIZE (MAX_SIZE)
  ) u_cmd_gen (
    .i_clk       (i_mem_clk),
    .i_clr       (w_clr),
    .i_load      (w_grant),
    .i_load_addr (w_grant_addr),
    .i_len       (r_len),
    .i_accept    (w_accept),
    .o_address   (o_local_address),
    .o_size      (o_local_size),
    .o_last      (w_cmd_last)
  );

`ifdef MEM_BURST_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] r_wd_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive active cycle without a command or beat.
  assign w_timeout = ~w_idle & ~(w_accept | w_strobe) &
                     (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_mem_clk) begin
    if (w_clr || w_idle || w_accept || w_strobe) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_grant && (i_rd_burst_len != '0)) begin
          w_state_nxt = ST_RD_CMD;
        end else if (w_wr_grant && (i_wr_burst_len != '0)) begin
          w_state_nxt = ST_WR_CMD;
        end
      end
      ST_RD_CMD: if (w_accept && w_cmd_last) w_state_nxt = ST_RD_WAIT;
      ST_WR_CMD: if (w_accept && w_cmd_last) w_state_nxt = ST_WR_WAIT;
      default: ;
    endcase
    if (w_final || w_timeout) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_mem_clk) begin
    if (w_clr) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_WR;
      r_zero_fin   <= 1'b0;
      r_len        <= '0;
      r_beat_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_zero_fin <= w_grant & (w_grant_len == '0);
      if (w_grant) begin
        r_last_grant <= w_rd_grant ? GRANT_RD : GRANT_WR;
        r_len        <= w_grant_len;
      end
      if (w_idle) begin
        r_beat_cnt <= '0;
      end else if (w_strobe) begin
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
      end
    end
  end

  assign o_rd_burst_ack        = w_rd_grant;
  assign o_wr_burst_ack        = w_wr_grant;
  assign o_burst_finish        = r_zero_fin | w_final;
  assign o_burst_busy          = ~w_idle;
  assign o_burst_error         = w_timeout;
  assign o_local_read_req      = (r_state == ST_RD_CMD);
  assign o_local_write_req     = (r_state == ST_WR_CMD);
  assign o_local_be            = '1;
  assign o_local_wdata         = i_wr_burst_data;
  assign o_wr_burst_data_req   = i_local_wdata_req;
  assign o_rd_burst_data_valid = i_local_rdata_valid;
  assign o_rd_burst_data       = i_local_rdata;

endmodule

// File: tb/tb_mem_burst_arb.sv
// Randomised bench for mem_burst_arb against a transaction-level reference model.
module tb_mem_burst_arb;

  localparam int DATA_W      = 64;
  localparam int ADDR_W      = 24;
  localparam int LEN_W       = 10;
  localparam int SIZE_W      = 2;
  localparam int MAX_SIZE    = 2;
  localparam int TIMEOUT_CYC = 16;

  logic                clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_rd_burst_req = 1'b0;
  logic [LEN_W-1:0]    i_rd_burst_len = '0;
  logic [ADDR_W-1:0]   i_rd_burst_addr = '0;
  logic                o_rd_burst_ack;
  logic                o_rd_burst_data_valid;
  logic [DATA_W-1:0]   o_rd_burst_data;
  logic                i_wr_burst_req = 1'b0;
  logic [LEN_W-1:0]    i_wr_burst_len = '0;
  logic [ADDR_W-1:0]   i_wr_burst_addr = '0;
  logic                o_wr_burst_ack;
  logic                o_wr_burst_data_req;
  logic [DATA_W-1:0]   i_wr_burst_data = '0;
  logic                o_burst_finish;
  logic                o_burst_busy;
  logic                o_burst_error;
  logic                i_local_initial_done = 1'b1;
  logic                i_local_ready = 1'b0;
  logic                o_local_read_req;
  logic                o_local_write_req;
  logic [ADDR_W-1:0]   o_local_address;
  logic [SIZE_W-1:0]   o_local_size;
  logic [DATA_W/8-1:0] o_local_be;
  logic                i_local_wdata_req = 1'b0;
  logic [DATA_W-1:0]   o_local_wdata;
  logic                i_local_rdata_valid = 1'b0;
  logic [DATA_W-1:0]   i_local_rdata = '0;

  always #5 clk = ~clk;

  mem_burst_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W),
    .MAX_SIZE(MAX_SIZE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_mem_clk(clk), .i_rst(i_rst),
    .i_rd_burst_req(i_rd_burst_req), .i_rd_burst_len(i_rd_burst_len),
    .i_rd_burst_addr(i_rd_burst_addr), .o_rd_burst_ack(o_rd_burst_ack),
    .o_rd_burst_data_valid(o_rd_burst_data_valid), .o_rd_burst_data(o_rd_burst_data),
    .i_wr_burst_req(i_wr_burst_req), .i_wr_burst_len(i_wr_burst_len),
    .i_wr_burst_addr(i_wr_burst_addr), .o_wr_burst_ack(o_wr_burst_ack),
    .o_wr_burst_data_req(o_wr_burst_data_req), .i_wr_burst_data(i_wr_burst_data),
    .o_burst_finish(o_burst_finish), .o_burst_busy(o_burst_busy),
    .o_burst_error(o_burst_error), .i_local_initial_done(i_local_initial_done),
    .i_local_ready(i_local_ready), .o_local_read_req(o_local_read_req),
    .o_local_write_req(o_local_write_req), .o_local_address(o_local_address),
    .o_local_size(o_local_size), .o_local_be(o_local_be),
    .i_local_wdata_req(i_local_wdata_req), .o_local_wdata(o_local_wdata),
    .i_local_rdata_valid(i_local_rdata_valid), .i_local_rdata(i_local_rdata)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                size;
  } cmd_t;

  int total = 0;
  int bad   = 0;

  // Reference model of one burst at a time: expected command list, beats owed by
  // accepted commands, beats seen, and the round-robin memory.
  cmd_t cmdq[$];
  bit   m_act = 0, m_dir = 0, m_last = 1, m_zero_fin = 0, m_chk_rst = 0;
  int   m_len = 0, m_beats = 0, m_owed = 0, m_quiet = 0;

  bit                rd_pend = 0, wr_pend = 0;
  logic [ADDR_W-1:0] rd_a = '0, wr_a = '0;
  logic [LEN_W-1:0]  rd_l = '0, wr_l = '0;
  int                p_ready = 100, p_beat = 100;
  bit                auto_req = 0, do_rst = 1, init_dn = 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [LEN_W-1:0] rand_len();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return LEN_W'(1);
      2:       return LEN_W'(2);
      default: return LEN_W'($urandom_range(3, 20));
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'(32'hFFFFFF - $urandom_range(0, 3));
    return ADDR_W'($urandom);
  endfunction

  task automatic check_cycle();
    bit clr, g_rd, g_wr, exp_fin, exp_err, exp_lrd, exp_lwr, stb, ev, dir;
    logic [ADDR_W-1:0] a;
    int len;
    clr = do_rst || !init_dn;
    g_rd = 0; g_wr = 0; exp_err = 0; ev = 0;
    if (!m_act && !clr) begin
      g_rd = rd_pend && (!wr_pend || m_last);
      g_wr = wr_pend && (!rd_pend || !m_last);
    end
    check_eq("rd_ack", o_rd_burst_ack, g_rd);
    check_eq("wr_ack", o_wr_burst_ack, g_wr);
    check_eq("busy", o_burst_busy, m_act);
    exp_fin = m_zero_fin;
    m_zero_fin = 0;
    exp_lrd = m_act && !m_dir && cmdq.size() > 0;
    exp_lwr = m_act &&  m_dir && cmdq.size() > 0;
    check_eq("local_read_req", o_local_read_req, exp_lrd);
    check_eq("local_write_req", o_local_write_req, exp_lwr);
    if (m_chk_rst) begin
      check_eq("addr_after_rst", o_local_address, 0);
      m_chk_rst = 0;
    end
    if (exp_lrd || exp_lwr) begin
      check_eq("cmd_addr", o_local_address, cmdq[0].addr);
      check_eq("cmd_size", o_local_size, cmdq[0].size);
      if (i_local_ready) begin
        m_owed += cmdq[0].size;
        cmdq.pop_front();
        ev = 1;
      end
    end
    if (m_act) begin
      stb = m_dir ? i_local_wdata_req : i_local_rdata_valid;
      if (stb) begin
        m_owed--;
        m_beats++;
        ev = 1;
        if (m_beats == m_len) begin
          exp_fin = 1;
          m_act = 0;
        end
      end
      if (ev) m_quiet = 0;
      else begin
        m_quiet++;
`ifdef MEM_BURST_TIMEOUT_EN
        if (m_quiet == TIMEOUT_CYC) begin
          exp_err = 1;
          m_act = 0;
        end
`endif
      end
    end
    check_eq("finish", o_burst_finish, exp_fin);
    check_eq("error", o_burst_error, exp_err);
    check_eq("rd_valid_pass", o_rd_burst_data_valid, i_local_rdata_valid);
    check_eq("rd_data_pass", o_rd_burst_data, i_local_rdata);
    check_eq("wr_req_pass", o_wr_burst_data_req, i_local_wdata_req);
    check_eq("wr_data_pass", o_local_wdata, i_wr_burst_data);
    if (!m_act) begin
      cmdq.delete();
      m_owed = 0;
    end
    if (g_rd || g_wr) begin
      dir    = g_wr;
      m_last = dir;
      len    = dir ? int'(wr_l) : int'(rd_l);
      a      = dir ? wr_a : rd_a;
      if (dir) wr_pend = 0; else rd_pend = 0;
      if (len == 0) m_zero_fin = 1;
      else begin
        m_act = 1; m_dir = dir; m_len = len; m_beats = 0; m_quiet = 0; m_owed = 0;
        cmdq.delete();
        for (int k = 0; k < len; k += MAX_SIZE)
          cmdq.push_back('{addr: ADDR_W'(a + k), size: (len - k < MAX_SIZE) ? len - k : MAX_SIZE});
      end
    end
    if (clr) begin
      m_act = 0; m_last = 1; m_zero_fin = 0; m_owed = 0;
      cmdq.delete();
      if (do_rst) begin
        rd_pend = 0; wr_pend = 0; m_chk_rst = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_req) begin
      if (!rd_pend && $urandom_range(0, 5) == 0) begin
        rd_pend = 1; rd_a = rand_addr(); rd_l = rand_len();
      end
      if (!wr_pend && $urandom_range(0, 5) == 0) begin
        wr_pend = 1; wr_a = rand_addr(); wr_l = rand_len();
      end
    end
    i_rst = do_rst;
    i_local_initial_done = init_dn;
    i_rd_burst_req = rd_pend; i_rd_burst_addr = rd_a; i_rd_burst_len = rd_l;
    i_wr_burst_req = wr_pend; i_wr_burst_addr = wr_a; i_wr_burst_len = wr_l;
    i_local_ready = ($urandom_range(0, 99) < p_ready);
    if (m_act && !m_dir) i_local_rdata_valid = (m_owed > 0) && ($urandom_range(0, 99) < p_beat);
    else                 i_local_rdata_valid = ($urandom_range(0, 3) == 0);
    if (m_act && m_dir)  i_local_wdata_req = (m_owed > 0) && ($urandom_range(0, 99) < p_beat);
    else                 i_local_wdata_req = ($urandom_range(0, 3) == 0);
    if (do_rst) begin
      i_local_rdata_valid = 0;
      i_local_wdata_req   = 0;
    end
    i_local_rdata   = {$urandom, $urandom};
    i_wr_burst_data = {$urandom, $urandom};
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_act || rd_pend || wr_pend || m_zero_fin) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_timeout", {63'd0, (m_act || rd_pend || wr_pend || m_zero_fin)}, 0);
  endtask

  initial begin
    logic [DATA_W/8-1:0] be_ones;
    int n;
    be_ones = '1;
    repeat (3) step();
    do_rst = 0;
    step();
    check_eq("local_be", o_local_be, be_ones);

    // Calibration pending: tied zero-length requests must wait.
    init_dn = 0;
    rd_pend = 1; rd_l = '0; rd_a = 24'h000010;
    wr_pend = 1; wr_l = '0; wr_a = 24'h000020;
    repeat (3) step();
    init_dn = 1;
    drain(20);
    rd_pend = 1; wr_pend = 1;
    drain(20);

    wr_pend = 1; wr_a = 24'h000100; wr_l = 10'd8;
    drain(100);
    rd_pend = 1; rd_a = 24'h000200; rd_l = 10'd5;
    drain(100);
    p_ready = 50;
    wr_pend = 1; wr_a = 24'h000400; wr_l = 10'd6;
    drain(100);
    wr_pend = 1; wr_a = 24'hFFFFFE; wr_l = 10'd4;
    drain(100);

    // Reset while the read waits for data.
    p_ready = 100; p_beat = 0;
    rd_pend = 1; rd_a = 24'h000300; rd_l = 10'd8;
    n = 0;
    while (!(m_act && cmdq.size() == 0) && n < 20) begin
      step();
      n++;
    end
    check_eq("reach_rd_wait", {63'd0, (m_act && cmdq.size() == 0)}, 1);
    do_rst = 1;
    step();
    do_rst = 0;
    step();

`ifdef MEM_BURST_TIMEOUT_EN
    rd_pend = 1; rd_a = 24'h000500; rd_l = 10'd4;
    drain(60);
`endif

    auto_req = 1;
    for (int blk = 0; blk < 15; blk++) begin
      p_ready = $urandom_range(20, 100);
      p_beat  = $urandom_range(20, 100);
      repeat (200) step();
    end
    auto_req = 0;
    p_ready = 100; p_beat = 100;
    drain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
